// File: rtl/mat_mult_seq.sv
// mat_mult_seq: sequential NxN unsigned matrix multiplier using one time-shared MAC.
// Define MAT_MULT_SEQ_SAT_EN to saturate result elements instead of wrapping them.
module mat_mult_seq #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int OW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*N*DW-1:0]   a_in,
  input  logic [N*N*DW-1:0]   b_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*N*OW-1:0]   res_out,
  output logic                busy
);
  localparam int ACCW = 2*DW + $clog2(N);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state;
  logic [N*N*DW-1:0] a_q, b_q;
  logic [DW-1:0] am [N][N];
  logic [DW-1:0] bm [N][N];
  logic [OW-1:0] rm [N][N];
  logic [ACCW-1:0] acc, acc_next;
  logic [2*DW-1:0] prod;
  logic [OW-1:0] res_el;
  logic [IW-1:0] i, j, k;
  for (genvar g = 0; g < N; g++) begin : g_row
    for (genvar h = 0; h < N; h++) begin : g_col
      assign am[g][h] = a_q[(N*N-1-(g*N+h))*DW +: DW];
      assign bm[g][h] = b_q[(N*N-1-(g*N+h))*DW +: DW];
      assign res_out[(N*N-1-(g*N+h))*OW +: OW] = rm[g][h];
    end
  end
  assign prod = {{DW{1'b0}}, am[i][k]} * {{DW{1'b0}}, bm[k][j]};
  assign acc_next = (k == '0 ? '0 : acc) + ACCW'(prod);
`ifdef MAT_MULT_SEQ_SAT_EN
  logic [ACCW+OW-1:0] ext;
  assign ext = {{OW{1'b0}}, acc_next};
  assign res_el = ext > {{ACCW{1'b0}}, {OW{1'b1}}} ? '1 : ext[OW-1:0];
`else
  assign res_el = OW'(acc_next);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rm        <= '{default: '0};
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q      <= a_in;
          b_q      <= b_in;
          acc      <= '0;
          i        <= '0;
          j        <= '0;
          k        <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= COMPUTE;
        end
        COMPUTE: begin
          acc <= acc_next;
          k   <= k == LAST ? '0 : k + 1'b1;
          if (k == LAST) begin
            rm[i][j] <= res_el;
            j <= j == LAST ? '0 : j + 1'b1;
            if (j == LAST) begin
              i <= i == LAST ? '0 : i + 1'b1;
              if (i == LAST) begin
                out_valid <= 1'b1;
                state     <= DONE;
              end
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_mult_seq.sv
// tb_mat_mult_seq: directed checks of mat_mult_seq at N=4/8-bit and N=2/DW=4/OW=10.
module tb_mat_mult_seq;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] a_in, b_in, res_out;
  logic in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [15:0] a_in2, b_in2;
  logic [39:0] res_out2;
  int ncmp = 0;
  int nerr = 0;
  int lat;
  bit ok, stable;
  logic [127:0] held;
  localparam logic [127:0] IDENT = 128'h01000000_00010000_00000100_00000001;
  localparam logic [127:0] BPAT  = 128'h01020304_05060708_090a0b0c_0d0e0f10;
`ifdef MAT_MULT_SEQ_SAT_EN
  localparam logic [127:0] OVF_EXP = {16{8'hff}};
`else
  localparam logic [127:0] OVF_EXP = {16{8'h04}};
`endif

  mat_mult_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .res_out(res_out), .busy(busy)
  );

  mat_mult_seq #(.N(2), .DW(4), .OW(10)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a_in(a_in2), .b_in(b_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .res_out(res_out2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [127:0] a, input logic [127:0] b);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Runs from the cycle after acceptance; lat ends as cycles since acceptance.
  task automatic wait_done(input bit scramble, output int l, output bit good);
    l = 1;
    good = 1'b1;
    while (!out_valid && l < 200) begin
      good &= busy && !in_ready;
      if (scramble) begin
        a_in = {4{$urandom}};
        b_in = {4{$urandom}};
      end
      tick();
      l++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_out_valid", out_valid, 1'b0);
    chk("post_hs_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a_in2 = '0; b_in2 = '0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res", res_out, '0);
    rst = 1'b0;
    tick();

    start_op(IDENT, BPAT);
    wait_done(1'b0, lat, ok);
    chk("ident_latency", lat, 65);
    chk("ident_busy", ok, 1'b1);
    chk("ident_res", res_out, BPAT);
    finish_op();

    start_op({16{8'hff}}, {16{8'hff}});
    wait_done(1'b0, lat, ok);
    chk("ovf_latency", lat, 65);
    chk("ovf_res", res_out, OVF_EXP);
    finish_op();

    start_op({16{8'h02}}, {16{8'h03}});
    wait_done(1'b1, lat, ok);
    chk("iso_latency", lat, 65);
    chk("iso_res", res_out, {16{8'h18}});
    held = res_out;
    stable = 1'b1;
    in_valid = 1'b1;
    a_in = IDENT;
    b_in = BPAT;
    for (int c = 0; c < 20; c++) begin
      tick();
      stable &= out_valid && !in_ready && busy && res_out === held;
    end
    chk("bp_stable", stable, 1'b1);
    chk("bp_res", res_out, {16{8'h18}});
    in_valid = 1'b0;
    finish_op();
    chk("bp_idle_busy", busy, 1'b0);

    start_op({16{8'hff}}, {16{8'hff}});
    repeat (30) tick();
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_res", res_out, '0);
    start_op({16{8'h01}}, BPAT);
    wait_done(1'b0, lat, ok);
    chk("fresh_latency", lat, 65);
    chk("fresh_res", res_out, {4{32'h1c202428}});
    finish_op();

    a_in2 = 16'hffff;
    b_in2 = 16'hffff;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 50) begin
      tick();
      lat++;
    end
    chk("n2_latency", lat, 9);
    chk("n2_res", res_out2, {4{10'h1c2}});
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    chk("n2_in_ready", in_ready2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
